// File: rtl/and_mux_arb_pkg.sv
// Shared constants and FSM state type for the and_mux_arbiter slice.
//   NUM_REQ : number of requesters sharing the AND unit
//   ID_W    : width of a requester index
//   state_e : arbiter FSM states
package and_mux_arb_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned ID_W    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/and_mux_unit.sv
// AND function built as a 2:1 mux: select = a, true arm = b, false arm = 0.
//   a : select operand
//   b : data operand (true arm)
//   y : a ? b : 1'b0
module and_mux_unit (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ? b : 1'b0;

endmodule

// File: rtl/and_mux_arbiter.sv
// Round-robin arbiter sharing one and_mux_unit among three requesters.
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/req_a/req_b : per-requester request and operands
//   req_ready             : per-requester accept (combinational, one-hot or zero)
//   rsp_valid/data/id     : registered response, held until rsp_ready
//   rsp_ready             : downstream accept
//   done_cnt              : wrapping count of completed response handshakes
module and_mux_arbiter
  import and_mux_arb_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_a,
  input  logic [NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               rsp_valid,
  output logic               rsp_data,
  output logic [ID_W-1:0]    rsp_id,
  input  logic               rsp_ready,
  output logic [CNT_W-1:0]   done_cnt
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ID_W-1:0]   grant_c;
  logic              found_c;
  logic              sel_a_c, sel_b_c, and_y_c;

  // Round-robin pick: first valid requester starting after last grant.
  always_comb begin
    logic [ID_W-1:0] cand;
    cand    = '0;
    grant_c = last_q;
    found_c = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(last_q) + k) % NUM_REQ);
      if (!found_c && req_valid[cand]) begin
        grant_c = cand;
        found_c = 1'b1;
      end
    end
  end

  // Route the granted operands into the single shared AND unit.
  assign sel_a_c = req_a[grant_c];
  assign sel_b_c = req_b[grant_c];

  and_mux_unit u_and_mux_unit (
    .a (sel_a_c),
    .b (sel_b_c),
    .y (and_y_c)
  );

  // Accept only in IDLE, only the granted requester, never during reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && found_c) begin
      req_ready[grant_c] = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A grant implies req_valid of the granted index, so it is a transfer.
        if (found_c) begin
          data_d  = and_y_c;
          id_d    = grant_c;
          last_d  = grant_c;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; last grant resets to 2 so 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      data_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign done_cnt  = cnt_q;

endmodule

// File: doc/and_mux_arbiter.md
AND_MUX_ARBITER -- requirements
Module: and_mux_arbiter

Interface
REQ-001 Parameter CNT_W, default 8: width of the completed-operation counter done_cnt.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port req_valid  input  3  per-requester operation request, bit i = requester i.
REQ-005 Port req_a  input  3  per-requester select operand (mux select).
REQ-006 Port req_b  input  3  per-requester data operand (mux true arm).
REQ-007 Port req_ready  output  3  per-requester accept, at most one bit high per cycle.
REQ-008 Port rsp_valid  output  1  response available.
REQ-009 Port rsp_data  output  1  result: a ? b : 1'b0 of the granted operands.
REQ-010 Port rsp_id  output  2  index (0..2) of the requester the response belongs to.
REQ-011 Port rsp_ready  input  1  downstream accepts the response.
REQ-012 Port done_cnt  output  CNT_W  count of completed response handshakes.

Function
REQ-013 Three requesters time-share exactly one AND unit built as a 2:1 mux: select = a, true arm = b, false arm = constant 1'b0.
REQ-014 FSM has two states: IDLE and RESP.
REQ-015 In IDLE, the grant goes to the first valid requester in round-robin order starting at (last_grant+1) mod 3.
REQ-016 req_ready[g] is high combinationally in IDLE for the granted index g only; all other bits are 0.
REQ-017 In RESP, all req_ready bits are 0.
REQ-018 Transfer occurs when req_valid[g] & req_ready[g] are both high.
REQ-019 On transfer, the next edge: registers rsp_data = req_a[g] ? req_b[g] : 0 and rsp_id = g, sets last_grant = g, and enters RESP.
REQ-020 Latency is 1 cycle: rsp_valid is high in the cycle after transfer.
REQ-021 In RESP, rsp_valid = 1, and rsp_data and rsp_id hold stable until rsp_valid & rsp_ready.
REQ-022 On the response handshake: return to IDLE and increment done_cnt by 1, wrapping modulo 2^CNT_W.
REQ-023 No back-to-back acceptance; maximum throughput is one operation per 2 cycles.
REQ-024 In IDLE with no req_valid bits set: remain in IDLE with last_grant unchanged.
REQ-025 Requesters hold req_valid and operands until their ready is seen; the arbiter places no requirement on a request withdrawn before acceptance.
REQ-026 Requests arriving while in RESP are only arbitrated after returning to IDLE; none are lost as long as valid is held.
REQ-027 rsp_ready asserted in IDLE has no effect.

Reset
REQ-028 While rst_n is low at a clock edge, the next state is: state = IDLE, last_grant = 2 (so requester 0 has first priority), rsp_valid = 0, rsp_data = 0, rsp_id = 0, done_cnt = 0.
REQ-029 req_ready is all 0 during any cycle in which rst_n is low.
REQ-030 Reset while in RESP discards the pending response without incrementing done_cnt.

Structure
REQ-031 Shared package and_mux_arb_pkg holds: NUM_REQ = 3, ID_W = 2, and the state enum {IDLE, RESP}.
REQ-032 The mux-based AND is a separate sub-module and_mux_unit (inputs a, b; output y = a ? b : 1'b0), instantiated exactly once.
REQ-033 The arbiter contains no other AND logic on the data path, so netlist pattern matching finds exactly one and_mux instance.
REQ-034 Expected size: roughly 120-200 lines of RTL in total.

Verification
REQ-035 Reset, then req_valid=001, a=1, b=1, rsp_ready=1 -> req_ready=001 in the same cycle; next cycle rsp_valid=1, rsp_data=1, rsp_id=0; done_cnt=1 after that.
REQ-036 Requester 1 only, over three separate operations with (a,b) = (0,1), (1,0), (0,0) -> rsp_data=0 each time (false arm is constant 0), rsp_id=1.
REQ-037 req_valid=111 held, rsp_ready=1 -> grant order 0,1,2,0,1,2; one response every 2 cycles; rsp_id follows the same sequence.
REQ-038 Hold rsp_ready=0 for 5 cycles in RESP with new req_valid=010 -> rsp_valid, rsp_data and rsp_id stable; req_ready=000; done_cnt unchanged; requester 1 is granted the cycle after rsp_ready rises and the handshake completes.
REQ-039 Drive rst_n=0 for one edge while in RESP -> next cycle rsp_valid=0 and done_cnt=0; with req_valid=111, the first grant goes to requester 0.
REQ-040 With CNT_W=2, complete 5 operations -> done_cnt sequence 1,2,3,0,1.
